// File: rtl/pe_tile_acc_if.sv
// Bus bundle for the PE outer-product tile: input beat channel, job config,
// result channel and status.
interface pe_tile_acc_if #(
    parameter int ROWS   = 2,
    parameter int COLS   = 16,
    parameter int DATA_W = 16,
    parameter int K_W    = 8,
    parameter int SH_W   = 6
);
    // Both channels use strict valid/ready: a transfer happens on a rising clk
    // edge where valid and ready are both high; the producer holds valid and
    // its payload stable until that edge, and valid never waits on ready.
    logic                         in_valid;
    logic                         in_ready;
    logic [COLS*DATA_W-1:0]       in_data;
    logic [ROWS*DATA_W-1:0]       in_weight;
    logic [K_W-1:0]               cfg_k_len;
    logic                         cfg_keep;
    logic                         cfg_round_en;
    logic [SH_W-1:0]              cfg_shift;
    logic                         out_valid;
    logic                         out_ready;
    logic [ROWS*COLS*DATA_W-1:0]  out_data;
    logic                         out_sat;
    logic                         busy;

    modport slave (
        input  in_valid, in_data, in_weight,
        input  cfg_k_len, cfg_keep, cfg_round_en, cfg_shift,
        input  out_ready,
        output in_ready, out_valid, out_data, out_sat, busy
    );

    modport master (
        output in_valid, in_data, in_weight,
        output cfg_k_len, cfg_keep, cfg_round_en, cfg_shift,
        output out_ready,
        input  in_ready, out_valid, out_data, out_sat, busy
    );
endinterface

// File: rtl/pe_tile_acc.sv
// ROWSxCOLS outer-product accumulate tile: acc[r][c] += w[r]*x[c] over K beats,
// then shift / round / saturate into a held valid/ready result.
module pe_tile_acc #(
    parameter int ROWS   = 2,
    parameter int COLS   = 16,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40,
    parameter int K_W    = 8,
    parameter int SH_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    pe_tile_acc_if.slave      bus,
    output logic [1:0]        o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_ROUND = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

    state_t                          r_state;
    state_t                          w_next;
    logic                            r_rdy;
    logic [K_W-1:0]                  r_k_len;
    logic [K_W-1:0]                  r_cnt;
    logic                            r_keep;
    logic                            r_round_en;
    logic [SH_W-1:0]                 r_shift;
    logic signed [ACC_W-1:0]         r_acc  [ROWS][COLS];
    logic [ROWS*COLS*DATA_W-1:0]     r_out_data;
    logic                            r_out_sat;

    logic signed [DATA_W-1:0]        w_a    [ROWS];
    logic signed [DATA_W-1:0]        w_x    [COLS];
    logic signed [2*DATA_W-1:0]      w_p    [ROWS][COLS];
    logic signed [ACC_W-1:0]         w_prod [ROWS][COLS];
    logic signed [ACC_W:0]           w_v    [ROWS][COLS];
    logic signed [ACC_W:0]           w_rnd;
    logic [ROWS*COLS*DATA_W-1:0]     w_res;
    logic                            w_sat_any;
    logic                            w_in_ready;
    logic                            w_in_fire;
    logic [K_W-1:0]                  w_k_eff;

    // r_rdy keeps in_ready low until the first clock after reset release.
    assign w_in_ready = r_rdy && ((r_state == S_IDLE) || (r_state == S_ACC));
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_k_eff    = (bus.cfg_k_len == '0) ? K_W'(1) : bus.cfg_k_len;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
    assign bus.busy      = (r_state != S_IDLE);
    assign o_dbg_state   = r_state;

    always_comb begin
        for (int r = 0; r < ROWS; r++) w_a[r] = bus.in_weight[r*DATA_W +: DATA_W];
        for (int c = 0; c < COLS; c++) w_x[c] = bus.in_data[c*DATA_W +: DATA_W];
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                w_p[r][c]    = (2*DATA_W)'(w_a[r]) * (2*DATA_W)'(w_x[c]);
                w_prod[r][c] = ACC_W'(w_p[r][c]);
            end
        end
    end

    // One extra bit of headroom so the rounding add cannot wrap.
    always_comb begin
        w_rnd     = '0;
        w_res     = '0;
        w_sat_any = 1'b0;
        if (r_round_en && (r_shift != '0)) w_rnd = (ACC_W+1)'(1) << (r_shift - SH_W'(1));
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                w_v[r][c] = ((ACC_W+1)'(r_acc[r][c]) + w_rnd) >>> r_shift;
                if (w_v[r][c] > SAT_MAX) begin
                    w_res[(r*COLS+c)*DATA_W +: DATA_W] = {1'b0, {(DATA_W-1){1'b1}}};
                    w_sat_any = 1'b1;
                end else if (w_v[r][c] < SAT_MIN) begin
                    w_res[(r*COLS+c)*DATA_W +: DATA_W] = {1'b1, {(DATA_W-1){1'b0}}};
                    w_sat_any = 1'b1;
                end else begin
                    w_res[(r*COLS+c)*DATA_W +: DATA_W] = w_v[r][c][DATA_W-1:0];
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_in_fire) w_next = (w_k_eff == K_W'(1)) ? S_ROUND : S_ACC;
            S_ACC:   if (w_in_fire && (r_cnt == r_k_len - K_W'(1))) w_next = S_ROUND;
            S_ROUND: w_next = S_HOLD;
            S_HOLD:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdy      <= 1'b0;
            r_k_len    <= '0;
            r_cnt      <= '0;
            r_keep     <= 1'b0;
            r_round_en <= 1'b0;
            r_shift    <= '0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    r_acc[r][c] <= '0;
        end else begin
            r_rdy <= 1'b1;
            case (r_state)
                S_IDLE: if (w_in_fire) begin
                    r_k_len    <= w_k_eff;
                    r_keep     <= bus.cfg_keep;
                    r_round_en <= bus.cfg_round_en;
                    r_shift    <= bus.cfg_shift;
                    r_cnt      <= K_W'(1);
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            r_acc[r][c] <= bus.cfg_keep ? (r_acc[r][c] + w_prod[r][c]) : w_prod[r][c];
                end
                S_ACC: if (w_in_fire) begin
                    r_cnt <= r_cnt + K_W'(1);
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++)
                            r_acc[r][c] <= r_acc[r][c] + w_prod[r][c];
                end
                S_ROUND: begin
                    r_out_data <= w_res;
                    r_out_sat  <= w_sat_any;
                end
                default: ;
            endcase
        end
    end
endmodule
